// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : control_unit
//  Purpose  : Multi-cycle control unit for the 16-bit datapath. It fetches an
//             instruction word, decodes it, and drives the datapath control
//             word. It also owns the program counter, the data-memory write
//             strobe, the branch/jump logic and a halt state.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             instr_in          - instruction word at pc_out (comb. memory)
//             zero_in           - datapath zero flag, valid during EXEC
//             addr_in           - datapath bus A (R[rsA]), JMP target
//             pc_out            - program counter
//             regWrite, rsA, rsB, rd, constant_in, MB, MD, op_select
//                               - datapath control word
//             mem_write         - data-memory write strobe
//             halted            - high while in HALT
//  Revision : 1.0 - initial release
// ============================================================================
module control_unit #(
    parameter int BUS_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BUS_WIDTH-1:0] instr_in,
    input  logic                 zero_in,
    input  logic [BUS_WIDTH-1:0] addr_in,
    output logic [BUS_WIDTH-1:0] pc_out,
    output logic                 regWrite,
    output logic [2:0]           rsA,
    output logic [2:0]           rsB,
    output logic [2:0]           rd,
    output logic [2:0]           constant_in,
    output logic                 MB,
    output logic                 MD,
    output logic [3:0]           op_select,
    output logic                 mem_write,
    output logic                 halted
);

    localparam logic [BUS_WIDTH-1:0] c_PC_ONE = BUS_WIDTH'(1);

    // Instruction classes (bits [15:13])
    localparam logic [2:0] c_CLS_ALU  = 3'b000;
    localparam logic [2:0] c_CLS_LD   = 3'b001;
    localparam logic [2:0] c_CLS_ST   = 3'b010;
    localparam logic [2:0] c_CLS_IMM  = 3'b100;
    localparam logic [2:0] c_CLS_BRNZ = 3'b101;
    localparam logic [2:0] c_CLS_BRZ  = 3'b110;
    localparam logic [2:0] c_CLS_SYS  = 3'b111;

    localparam logic [3:0] c_FN_JMP  = 4'b0000;
    localparam logic [3:0] c_FN_HALT = 4'b1111;
    localparam logic [3:0] c_OP_MOVA = 4'b0000;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_EXEC   = 2'd1,
        ST_LOADWB = 2'd2,
        ST_HALT   = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [BUS_WIDTH-1:0]   pc_q, pc_d;
    logic [BUS_WIDTH-1:0]   ir_q, ir_d;

    logic                   w_reg_write;
    logic                   w_mem_write;

    // Decoded instruction fields
    logic [2:0]             w_cls;
    logic [3:0]             w_fn;
    logic [2:0]             w_dr;
    logic [2:0]             w_sa;
    logic [2:0]             w_sb;
    logic [BUS_WIDTH-1:0]   w_br_offset;

    assign w_cls = ir_q[15:13];
    assign w_fn  = ir_q[12:9];
    assign w_dr  = ir_q[8:6];
    assign w_sa  = ir_q[5:3];
    assign w_sb  = ir_q[2:0];

    // Branch displacement is the 6-bit field {DR,SB}, sign-extended so that
    // the PC addition wraps naturally modulo 2^BUS_WIDTH.
    assign w_br_offset = {{(BUS_WIDTH-6){w_dr[2]}}, w_dr, w_sb};

    // ------------------------------------------------------------------
    // State, PC and IR registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control-word decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        w_reg_write = 1'b0;
        w_mem_write = 1'b0;
        rsA         = 3'd0;
        rsB         = 3'd0;
        rd          = 3'd0;
        constant_in = 3'd0;
        MB          = 1'b0;
        MD          = 1'b0;
        op_select   = 4'd0;

        case (state_q)
            ST_FETCH: begin
                ir_d    = instr_in;
                state_d = ST_EXEC;
            end

            ST_EXEC: begin
                rsA         = w_sa;
                rsB         = w_sb;
                rd          = w_dr;
                constant_in = w_sb;
                op_select   = w_fn;
                pc_d        = pc_q + c_PC_ONE;
                state_d     = ST_FETCH;

                case (w_cls)
                    c_CLS_ALU: begin
                        w_reg_write = 1'b1;
                    end
                    c_CLS_IMM: begin
                        w_reg_write = 1'b1;
                        MB          = 1'b1;
                    end
                    c_CLS_LD: begin
                        // EU passes bus A through as the memory address; the
                        // register write is deferred to LOADWB.
                        op_select = c_OP_MOVA;
                        state_d   = ST_LOADWB;
                    end
                    c_CLS_ST: begin
                        w_mem_write = 1'b1;
                    end
                    c_CLS_BRZ: begin
                        // MOVA makes zero_in reflect R[SA] itself.
                        op_select = c_OP_MOVA;
                        if (zero_in) begin
                            pc_d = pc_q + w_br_offset;
                        end
                    end
                    c_CLS_BRNZ: begin
                        op_select = c_OP_MOVA;
                        if (!zero_in) begin
                            pc_d = pc_q + w_br_offset;
                        end
                    end
                    c_CLS_SYS: begin
                        if (w_fn == c_FN_JMP) begin
                            pc_d = addr_in;
                        end else if (w_fn == c_FN_HALT) begin
                            pc_d    = pc_q;
                            state_d = ST_HALT;
                        end
                    end
                    default: begin
                        // Class 011 and unused system functions are NOPs.
                    end
                endcase
            end

            ST_LOADWB: begin
                MD          = 1'b1;
                rd          = w_dr;
                w_reg_write = 1'b1;
                state_d     = ST_FETCH;
            end

            ST_HALT: begin
                state_d = ST_HALT;
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // Write strobes are suppressed combinationally during reset so that no
    // register or memory write lands on a reset edge.
    assign regWrite  = w_reg_write & ~rst;
    assign mem_write = w_mem_write & ~rst;
    assign halted    = (state_q == ST_HALT);
    assign pc_out    = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_control_unit
//  Purpose  : Self-checking bench for control_unit: a table of directed
//             instruction vectors, hand-written multi-cycle corner cases,
//             and randomized instructions checked against a reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_control_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr_in;
    logic        zero_in;
    logic [15:0] addr_in;
    logic [15:0] pc_out;
    logic        regWrite;
    logic [2:0]  rsA, rsB, rd, constant_in;
    logic        MB, MD;
    logic [3:0]  op_select;
    logic        mem_write;
    logic        halted;

    control_unit #(.BUS_WIDTH(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_in    (instr_in),
        .zero_in     (zero_in),
        .addr_in     (addr_in),
        .pc_out      (pc_out),
        .regWrite    (regWrite),
        .rsA         (rsA),
        .rsB         (rsB),
        .rd          (rd),
        .constant_in (constant_in),
        .MB          (MB),
        .MD          (MD),
        .op_select   (op_select),
        .mem_write   (mem_write),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    // Packed view of every control output:
    // {regWrite, mem_write, MB, MD, halted, op_select, rd, rsA, rsB, constant_in}
    logic [20:0] ctl;
    assign ctl = {regWrite, mem_write, MB, MD, halted, op_select, rd, rsA, rsB, constant_in};

    localparam logic [20:0] c_WR_MASK = 21'h07FFFF;

    int n_pass  = 0;
    int n_total = 0;

    function automatic logic [20:0] mk(input bit rw, input bit mw, input bit mb,
                                       input bit md, input bit h, input logic [3:0] op,
                                       input logic [2:0] d, input logic [2:0] a,
                                       input logic [2:0] b, input logic [2:0] c);
        return {rw, mw, mb, md, h, op, d, a, b, c};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Runs one instruction from FETCH; leaves the bench at the next FETCH.
    task automatic do_instr(input string nm, input logic [15:0] ins, input logic z,
                            input logic [15:0] a, input logic [20:0] exp_ctl,
                            input logic [15:0] exp_pc, input bit ld);
        instr_in = ins;
        zero_in  = z;
        addr_in  = a;
        #1;
        chk({nm, " fetch"}, 32'(ctl), 32'(mk(0,0,0,0,0,4'd0,3'd0,3'd0,3'd0,3'd0)));
        step();
        chk({nm, " exec"}, 32'(ctl), 32'(exp_ctl));
        step();
        chk({nm, " pc"}, 32'(pc_out), 32'(exp_pc));
        if (ld) begin
            chk({nm, " loadwb"}, 32'(ctl), 32'(mk(1,0,0,1,0,4'd0,ins[8:6],3'd0,3'd0,3'd0)));
            step();
            chk({nm, " pc after loadwb"}, 32'(pc_out), 32'(exp_pc));
        end
    endtask

    task automatic goto_pc(input logic [15:0] target);
        do_instr("setup jmp", 16'hE000, 1'b0, target,
                 mk(0,0,0,0,0,4'd0,3'd0,3'd0,3'd0,3'd0), target, 1'b0);
    endtask

    // Reference model: the EXEC-cycle control word and the resulting PC for
    // one instruction, computed from the instruction-set rules.
    task automatic model(input logic [15:0] ins, input logic z, input logic [15:0] a,
                         input logic [15:0] pc, output logic [20:0] e_ctl,
                         output logic [15:0] e_pc, output bit e_ld);
        int          cls, fn, off;
        bit          rw, mw, mb, taken;
        logic [3:0]  op;
        cls   = int'(ins[15:13]);
        fn    = int'(ins[12:9]);
        off   = int'({ins[8:6], ins[2:0]});
        if (off >= 32) off -= 64;
        rw = 0; mw = 0; mb = 0; taken = 0; e_ld = 0;
        op   = ins[12:9];
        e_pc = pc + 16'd1;
        case (cls)
            0: rw = 1;
            4: begin rw = 1; mb = 1; end
            1: begin op = 4'd0; e_ld = 1; end
            2: mw = 1;
            6: begin op = 4'd0; taken = (z == 1'b1); end
            5: begin op = 4'd0; taken = (z == 1'b0); end
            7: begin
                if (fn == 0) e_pc = a;
                else if (fn == 15) e_pc = pc;
            end
            default: ;
        endcase
        if (taken) e_pc = 16'((int'(pc) + off) & 32'hFFFF);
        e_ctl = mk(rw, mw, mb, 1'b0, 1'b0, op, ins[8:6], ins[5:3], ins[2:0], ins[2:0]);
    endtask

    typedef struct {
        string       name;
        logic [15:0] pc0;
        logic [15:0] instr;
        logic        z;
        logic [15:0] a;
        logic [20:0] exp_ctl;
        logic [15:0] exp_pc;
        bit          ld;
    } vec_t;

    vec_t vt[13];

    initial begin
        logic [20:0] e_ctl;
        logic [15:0] e_pc;
        logic [15:0] m_pc;
        logic [15:0] ins;
        logic        z;
        logic [15:0] a;
        bit          e_ld;

        vt[0]  = '{"add",       16'h0000, 16'h0413, 1'b0, 16'h0000, mk(1,0,0,0,0,4'd2,3'd0,3'd2,3'd3,3'd3), 16'h0001, 1'b0};
        vt[1]  = '{"imm",       16'h0020, 16'h840F, 1'b0, 16'h0000, mk(1,0,1,0,0,4'd2,3'd0,3'd1,3'd7,3'd7), 16'h0021, 1'b0};
        vt[2]  = '{"ld",        16'h0030, 16'h2160, 1'b0, 16'h0000, mk(0,0,0,0,0,4'd0,3'd5,3'd4,3'd0,3'd0), 16'h0031, 1'b1};
        vt[3]  = '{"st",        16'h0040, 16'h4ACA, 1'b0, 16'h0000, mk(0,1,0,0,0,4'd5,3'd3,3'd1,3'd2,3'd2), 16'h0041, 1'b0};
        vt[4]  = '{"brz taken", 16'h0010, 16'hC7CC, 1'b1, 16'h0000, mk(0,0,0,0,0,4'd0,3'd7,3'd1,3'd4,3'd4), 16'h000C, 1'b0};
        vt[5]  = '{"brz not",   16'h0010, 16'hC7CC, 1'b0, 16'h0000, mk(0,0,0,0,0,4'd0,3'd7,3'd1,3'd4,3'd4), 16'h0011, 1'b0};
        vt[6]  = '{"brnz wrap", 16'h0002, 16'hA7CC, 1'b0, 16'h0000, mk(0,0,0,0,0,4'd0,3'd7,3'd1,3'd4,3'd4), 16'hFFFE, 1'b0};
        vt[7]  = '{"brnz not",  16'h0002, 16'hA7CC, 1'b1, 16'h0000, mk(0,0,0,0,0,4'd0,3'd7,3'd1,3'd4,3'd4), 16'h0003, 1'b0};
        vt[8]  = '{"jmp",       16'h0040, 16'hE010, 1'b0, 16'hFFFF, mk(0,0,0,0,0,4'd0,3'd0,3'd2,3'd0,3'd0), 16'hFFFF, 1'b0};
        vt[9]  = '{"nop wrap",  16'hFFFF, 16'h6C53, 1'b0, 16'h0000, mk(0,0,0,0,0,4'd6,3'd1,3'd2,3'd3,3'd3), 16'h0000, 1'b0};
        vt[10] = '{"nop sys",   16'h0005, 16'hEE00, 1'b1, 16'h1234, mk(0,0,0,0,0,4'd7,3'd0,3'd0,3'd0,3'd0), 16'h0006, 1'b0};
        vt[11] = '{"brz +31",   16'h0100, 16'hC0C7, 1'b1, 16'h0000, mk(0,0,0,0,0,4'd0,3'd3,3'd0,3'd7,3'd7), 16'h011F, 1'b0};
        vt[12] = '{"brz -32",   16'h0100, 16'hC100, 1'b1, 16'h0000, mk(0,0,0,0,0,4'd0,3'd4,3'd0,3'd0,3'd0), 16'h00E0, 1'b0};

        rst      = 1'b1;
        instr_in = 16'h0000;
        zero_in  = 1'b0;
        addr_in  = 16'h0000;
        step();
        step();
        chk("reset ctl", 32'(ctl), 32'd0);
        chk("reset pc", 32'(pc_out), 32'd0);
        rst = 1'b0;

        // ---------------- Directed vector table ----------------
        for (int i = 0; i < 13; i++) begin
            goto_pc(vt[i].pc0);
            do_instr(vt[i].name, vt[i].instr, vt[i].z, vt[i].a,
                     vt[i].exp_ctl, vt[i].exp_pc, vt[i].ld);
        end

        // ---------------- HALT and recovery ----------------
        goto_pc(16'h0050);
        instr_in = 16'hFE00;
        #1;
        step();
        chk("halt exec", 32'(ctl), 32'(mk(0,0,0,0,0,4'hF,3'd0,3'd0,3'd0,3'd0)));
        for (int i = 0; i < 10; i++) begin
            step();
            chk("halted ctl", 32'(ctl), 32'(mk(0,0,0,0,1,4'd0,3'd0,3'd0,3'd0,3'd0)));
            chk("halted pc", 32'(pc_out), 32'h0050);
        end
        do_reset();
        chk("after halt rst ctl", 32'(ctl), 32'd0);
        chk("after halt rst pc", 32'(pc_out), 32'd0);

        // ---------------- Reset during EXEC of ADD ----------------
        goto_pc(16'h0077);
        instr_in = 16'h0413;
        #1;
        step();
        rst = 1'b1;
        #1;
        chk("rst exec gated", 32'(ctl), 32'(mk(0,0,0,0,0,4'd2,3'd0,3'd2,3'd3,3'd3)));
        step();
        rst = 1'b0;
        chk("rst exec pc", 32'(pc_out), 32'd0);
        chk("rst exec fetch", 32'(ctl), 32'd0);

        // ---------------- Reset during LOADWB ----------------
        goto_pc(16'h0033);
        instr_in = 16'h2160;
        #1;
        step();
        step();
        rst = 1'b1;
        #1;
        chk("rst loadwb gated", 32'(ctl), 32'(mk(0,0,0,1,0,4'd0,3'd5,3'd0,3'd0,3'd0)));
        step();
        rst = 1'b0;
        chk("rst loadwb pc", 32'(pc_out), 32'd0);
        chk("rst loadwb fetch", 32'(ctl), 32'd0);
        instr_in = 16'h0413;
        #1;
        step();
        chk("post rst exec", 32'(ctl), 32'(mk(1,0,0,0,0,4'd2,3'd0,3'd2,3'd3,3'd3)));
        step();

        // ---------------- Held reset ----------------
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("held rst ctl", 32'(ctl), 32'd0);
            chk("held rst pc", 32'(pc_out), 32'd0);
        end
        rst = 1'b0;

        // ---------------- Randomized against reference model ----------------
        m_pc = 16'h0000;
        for (int i = 0; i < 300; i++) begin
            ins = 16'($urandom);
            if (ins[15:9] == 7'h7F) ins[9] = 1'b0;
            z   = 1'($urandom);
            a   = 16'($urandom);
            model(ins, z, a, m_pc, e_ctl, e_pc, e_ld);
            instr_in = ins;
            zero_in  = z;
            addr_in  = a;
            #1;
            chk("rand fetch", 32'(ctl), 32'd0);
            step();
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1;
                #1;
                chk("rand rst exec", 32'(ctl), 32'(e_ctl & c_WR_MASK));
                step();
                rst  = 1'b0;
                m_pc = 16'h0000;
                chk("rand rst pc", 32'(pc_out), 32'(m_pc));
            end else begin
                chk("rand exec", 32'(ctl), 32'(e_ctl));
                step();
                m_pc = e_pc;
                chk("rand pc", 32'(pc_out), 32'(m_pc));
                if (e_ld) begin
                    chk("rand loadwb", 32'(ctl), 32'(mk(1,0,0,1,0,4'd0,ins[8:6],3'd0,3'd0,3'd0)));
                    step();
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
